// File: rtl/dp_ram_rsp.sv
// dp_ram_rsp: dual-port RAM responder. Ports A and B each get a req/ack
// handshake and registered read data. The block also arbitrates
// write-write collisions to the same word and gives read-first behaviour
// when one port reads a word that the other port writes on the same edge.
// Optional macro RAM_CLEAR_EN adds a zeroing sweep after reset; busy is
// held high during the sweep.
//
// state   | meaning
// S_CLEAR | sweep writes 0 to one word per cycle, busy=1 (RAM_CLEAR_EN only)
// S_IDLE  | serving requests, busy=0
module dp_ram_rsp #(
   parameter int AW = 3,
   parameter int DW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_ack,
   output logic [DW-1:0] a_rdata,
   output logic          a_rvalid,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_ack,
   output logic [DW-1:0] b_rdata,
   output logic          b_rvalid,
   output logic [7:0]    coll_cnt,
   output logic          busy
);

   localparam int DEPTH = 2**AW;

   logic [DW-1:0] mem [DEPTH];
   logic          a_elig;
   logic          b_elig;
   logic          wr_coll;
   logic          a_take;
   logic          b_take;
   logic          prio_b;

   // A port is eligible when it requests while the block is not busy. It
   // must also not be inside its own ack cycle: a request still high during
   // the ack cycle is treated as a new request and is taken one edge later.
   // This gives the req -> ack -> next req rhythm.
   always_comb begin
      a_elig  = a_req && !busy && !a_ack;
      b_elig  = b_req && !busy && !b_ack;
      wr_coll = a_elig && b_elig && a_we && b_we && (a_addr == b_addr);
      a_take  = a_elig && !(wr_coll && prio_b);
      b_take  = b_elig && !(wr_coll && !prio_b);
   end

   // Handshake outputs, registered read data, priority pointer and collision count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_ack    <= 1'b0;
         a_rvalid <= 1'b0;
         a_rdata  <= '0;
         b_ack    <= 1'b0;
         b_rvalid <= 1'b0;
         b_rdata  <= '0;
         prio_b   <= 1'b0;
         coll_cnt <= 8'd0;
      end else begin
         a_ack    <= a_take;
         a_rvalid <= a_take && !a_we;
         if (a_take && !a_we) begin
            a_rdata <= mem[a_addr];
         end
         b_ack    <= b_take;
         b_rvalid <= b_take && !b_we;
         if (b_take && !b_we) begin
            b_rdata <= mem[b_addr];
         end
         if (wr_coll) begin
            prio_b <= !prio_b;
            if (coll_cnt != 8'hff) begin
               coll_cnt <= coll_cnt + 8'd1;
            end
         end
      end
   end

`ifdef RAM_CLEAR_EN
   typedef enum logic {S_CLEAR, S_IDLE} state_t;

   state_t        state;
   logic [AW-1:0] clr_addr;

   // Post-reset sweep; a reset during the sweep restarts it from word 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_CLEAR;
         clr_addr <= '0;
         busy     <= 1'b1;
      end else begin
         case (state)
            S_CLEAR: begin
               clr_addr <= clr_addr + 1'b1;
               if (clr_addr == AW'(DEPTH-1)) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               busy <= 1'b0;
            end
         endcase
      end
   end

   // Storage: the sweep and port writes never overlap because busy blocks the ports
   always_ff @(posedge clk) begin
      if (state == S_CLEAR) begin
         mem[clr_addr] <= '0;
      end
      if (a_take && a_we) begin
         mem[a_addr] <= a_wdata;
      end
      if (b_take && b_we) begin
         mem[b_addr] <= b_wdata;
      end
   end
`else
   assign busy = 1'b0;

   // Storage: a same-word write pair is never taken together, so the order here is irrelevant
   always_ff @(posedge clk) begin
      if (a_take && a_we) begin
         mem[a_addr] <= a_wdata;
      end
      if (b_take && b_we) begin
         mem[b_addr] <= b_wdata;
      end
   end
`endif

endmodule
